// File: rtl/id_ex_hazard_register_if.sv
// ID/EX pipeline bus: decoder outputs and operands in, registered EX fields
// and load-use stall controls out.
interface id_ex_hazard_register_if #(
    parameter int DATA_W      = 32,
    parameter int STALL_CNT_W = 16
);
    logic [5:0]             id_opcode;
    logic                   id_reg_dst;
    logic                   id_branch;
    logic                   id_mem_read;
    logic                   id_mem_to_reg;
    logic                   id_mem_write;
    logic                   id_alu_src;
    logic                   id_reg_write;
    logic                   id_jump;
    logic [1:0]             id_alu_op;
    logic [DATA_W-1:0]      id_pc_plus4;
    logic [DATA_W-1:0]      id_rd1;
    logic [DATA_W-1:0]      id_rd2;
    logic [DATA_W-1:0]      id_imm;
    logic [4:0]             id_rs;
    logic [4:0]             id_rt;
    logic [4:0]             id_rd;
    logic [5:0]             id_funct;
    logic                   flush;

    logic                   ex_reg_dst;
    logic                   ex_branch;
    logic                   ex_mem_read;
    logic                   ex_mem_to_reg;
    logic                   ex_mem_write;
    logic                   ex_alu_src;
    logic                   ex_reg_write;
    logic                   ex_jump;
    logic [1:0]             ex_alu_op;
    logic [DATA_W-1:0]      ex_pc_plus4;
    logic [DATA_W-1:0]      ex_rd1;
    logic [DATA_W-1:0]      ex_rd2;
    logic [DATA_W-1:0]      ex_imm;
    logic [4:0]             ex_rs;
    logic [4:0]             ex_rt;
    logic [4:0]             ex_rd;
    logic [5:0]             ex_funct;
    logic                   pc_write;
    logic                   if_id_write;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output id_opcode, id_reg_dst, id_branch, id_mem_read, id_mem_to_reg,
        output id_mem_write, id_alu_src, id_reg_write, id_jump, id_alu_op,
        output id_pc_plus4, id_rd1, id_rd2, id_imm,
        output id_rs, id_rt, id_rd, id_funct, flush,
        input  ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg,
        input  ex_mem_write, ex_alu_src, ex_reg_write, ex_jump, ex_alu_op,
        input  ex_pc_plus4, ex_rd1, ex_rd2, ex_imm,
        input  ex_rs, ex_rt, ex_rd, ex_funct,
        input  pc_write, if_id_write, stall_count
    );

    modport slave (
        input  id_opcode, id_reg_dst, id_branch, id_mem_read, id_mem_to_reg,
        input  id_mem_write, id_alu_src, id_reg_write, id_jump, id_alu_op,
        input  id_pc_plus4, id_rd1, id_rd2, id_imm,
        input  id_rs, id_rt, id_rd, id_funct, flush,
        output ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg,
        output ex_mem_write, ex_alu_src, ex_reg_write, ex_jump, ex_alu_op,
        output ex_pc_plus4, ex_rd1, ex_rd2, ex_imm,
        output ex_rs, ex_rt, ex_rd, ex_funct,
        output pc_write, if_id_write, stall_count
    );
endinterface

// File: rtl/id_ex_hazard_register.sv
// ID/EX pipeline register with load-use bubble insertion, control
// sanitisation and a saturating stall counter.
module id_ex_hazard_register #(
    parameter int DATA_W      = 32,
    parameter int STALL_CNT_W = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    id_ex_hazard_register_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef struct packed {
        logic       reg_dst;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       jump;
        logic [1:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        logic [DATA_W-1:0] pc_plus4;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [5:0]        funct;
    } data_t;

    ctrl_t                  ctrl_q;
    ctrl_t                  ctrl_id;
    data_t                  data_q;
    data_t                  data_id;
    logic [STALL_CNT_W-1:0] cnt_q;
    logic                   uses_rs;
    logic                   uses_rt;
    logic                   hazard;

    // Decoder don't-cares are replaced so downstream stages never act on them
    always_comb begin
        ctrl_id            = '0;
        ctrl_id.reg_dst    = (bus.id_opcode == OP_RTYPE);
        ctrl_id.branch     = bus.id_branch;
        ctrl_id.mem_read   = (bus.id_opcode == OP_LW);
        ctrl_id.mem_to_reg = bus.id_mem_to_reg;
        ctrl_id.mem_write  = bus.id_mem_write;
        ctrl_id.alu_src    = bus.id_alu_src;
        ctrl_id.reg_write  = bus.id_reg_write & ~bus.id_jump;
        ctrl_id.jump       = bus.id_jump;
        ctrl_id.alu_op     = bus.id_alu_op;
    end

    assign data_id = '{
        pc_plus4: bus.id_pc_plus4,
        rd1:      bus.id_rd1,
        rd2:      bus.id_rd2,
        imm:      bus.id_imm,
        rs:       bus.id_rs,
        rt:       bus.id_rt,
        rd:       bus.id_rd,
        funct:    bus.id_funct
    };

    assign uses_rs = (bus.id_opcode != OP_J);
    assign uses_rt = (bus.id_opcode == OP_RTYPE) ||
                     (bus.id_opcode == OP_SW) ||
                     (bus.id_opcode == OP_BEQ);

    assign hazard = ctrl_q.mem_read && (data_q.rt != 5'd0) &&
                    ((uses_rs && (data_q.rt == bus.id_rs)) ||
                     (uses_rt && (data_q.rt == bus.id_rt))) &&
                    !bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_id;
            if (bus.flush || hazard) begin
                ctrl_q <= '0;
            end else begin
                ctrl_q <= ctrl_id;
            end
            if (hazard && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.ex_reg_dst    = ctrl_q.reg_dst;
    assign bus.ex_branch     = ctrl_q.branch;
    assign bus.ex_mem_read   = ctrl_q.mem_read;
    assign bus.ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign bus.ex_mem_write  = ctrl_q.mem_write;
    assign bus.ex_alu_src    = ctrl_q.alu_src;
    assign bus.ex_reg_write  = ctrl_q.reg_write;
    assign bus.ex_jump       = ctrl_q.jump;
    assign bus.ex_alu_op     = ctrl_q.alu_op;
    assign bus.ex_pc_plus4   = data_q.pc_plus4;
    assign bus.ex_rd1        = data_q.rd1;
    assign bus.ex_rd2        = data_q.rd2;
    assign bus.ex_imm        = data_q.imm;
    assign bus.ex_rs         = data_q.rs;
    assign bus.ex_rt         = data_q.rt;
    assign bus.ex_rd         = data_q.rd;
    assign bus.ex_funct      = data_q.funct;
    assign bus.pc_write      = ~hazard;
    assign bus.if_id_write   = ~hazard;
    assign bus.stall_count   = cnt_q;
endmodule

// File: tb/tb_id_ex_hazard_register.sv
// Directed bench for id_ex_hazard_register: reset, load-use stall, false
// hazards, flush priority, sanitisation and counter saturation.
module tb_id_ex_hazard_register;
    localparam int DW = 32;
    localparam int CW = 2;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    id_ex_hazard_register_if #(.DATA_W(DW), .STALL_CNT_W(CW)) bus ();

    id_ex_hazard_register #(.DATA_W(DW), .STALL_CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] ex_ctrl();
        return {bus.ex_reg_dst, bus.ex_branch, bus.ex_mem_read,
                bus.ex_mem_to_reg, bus.ex_mem_write, bus.ex_alu_src,
                bus.ex_reg_write, bus.ex_jump, bus.ex_alu_op};
    endfunction

    task automatic drive(input logic [5:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd,
                         input logic [9:0] c);
        {bus.id_reg_dst, bus.id_branch, bus.id_mem_read, bus.id_mem_to_reg,
         bus.id_mem_write, bus.id_alu_src, bus.id_reg_write, bus.id_jump,
         bus.id_alu_op} = c;
        bus.id_opcode   = op;
        bus.id_rs       = rs;
        bus.id_rt       = rt;
        bus.id_rd       = rd;
        bus.id_funct    = 6'h20;
        bus.id_pc_plus4 = 32'h0000_1004;
        bus.id_rd1      = 32'h1234_0000 | 32'(rs);
        bus.id_rd2      = 32'h5678_0000 | 32'(rt);
        bus.id_imm      = 32'hFFFF_FFF0;
    endtask

    // control order: dst br mrd m2r mwr asrc rwr jmp aluop[1:0]
    task automatic lw(input logic [4:0] rt);
        drive(6'b100011, 5'd9, rt, 5'd0, 10'b0_0_1_1_0_1_1_0_00);
    endtask

    task automatic add(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd);
        drive(6'b000000, rs, rt, rd, 10'b1_0_0_0_0_0_1_0_10);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.flush = 1'b0;
        add(5'd1, 5'd2, 5'd3);
        step();
        step();
        chk("rst_ctrl", 32'(ex_ctrl()), 32'd0);
        chk("rst_cnt", 32'(bus.stall_count), 32'd0);
        chk("rst_pcw", 32'(bus.pc_write), 32'd1);
        rst_n = 1'b1;

        // latency, then asynchronous reset mid-cycle
        add(5'd4, 5'd5, 5'd6);
        step();
        chk("lat_rd1", bus.ex_rd1, 32'h1234_0004);
        chk("lat_rd", 32'(bus.ex_rd), 32'd6);
        chk("lat_ctrl", 32'(ex_ctrl()), 32'h20A);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ctrl", 32'(ex_ctrl()), 32'd0);
        chk("arst_rd1", bus.ex_rd1, 32'd0);
        chk("arst_pcw", 32'(bus.pc_write), 32'd1);
        chk("arst_ifid", 32'(bus.if_id_write), 32'd1);
        chk("arst_cnt", 32'(bus.stall_count), 32'd0);
        #1;
        rst_n = 1'b1;

        // load-use: lw $8 then add rs=8
        step();
        lw(5'd8);
        step();
        chk("lu_exmrd", 32'(bus.ex_mem_read), 32'd1);
        add(5'd8, 5'd10, 5'd11);
        #1;
        chk("lu_pcw0", 32'(bus.pc_write), 32'd0);
        chk("lu_ifid0", 32'(bus.if_id_write), 32'd0);
        step();
        chk("lu_bub_rw", 32'(bus.ex_reg_write), 32'd0);
        chk("lu_bub_ctrl", 32'(ex_ctrl()), 32'd0);
        chk("lu_cnt1", 32'(bus.stall_count), 32'd1);
        chk("lu_pcw1", 32'(bus.pc_write), 32'd1);
        step();
        chk("lu_rel_dst", 32'(bus.ex_reg_dst), 32'd1);
        chk("lu_rel_aop", 32'(bus.ex_alu_op), 32'd2);
        chk("lu_rel_rw", 32'(bus.ex_reg_write), 32'd1);
        chk("lu_rel_rd", 32'(bus.ex_rd), 32'd11);

        // lw rt=8 then addi rt=8 rs=9: addi does not read rt
        lw(5'd8);
        step();
        drive(6'b001000, 5'd9, 5'd8, 5'd0, 10'b1_0_1_0_0_1_1_0_00);
        #1;
        chk("nf_addi_pcw", 32'(bus.pc_write), 32'd1);
        step();
        chk("san_addi_mrd", 32'(bus.ex_mem_read), 32'd0);
        chk("san_addi_dst", 32'(bus.ex_reg_dst), 32'd0);
        chk("san_addi_rw", 32'(bus.ex_reg_write), 32'd1);
        chk("nf_addi_cnt", 32'(bus.stall_count), 32'd1);

        // lw to $0 never stalls
        lw(5'd0);
        step();
        add(5'd0, 5'd0, 5'd3);
        #1;
        chk("nf_r0_pcw", 32'(bus.pc_write), 32'd1);
        step();
        chk("nf_r0_cnt", 32'(bus.stall_count), 32'd1);

        // flush overrides the hazard
        lw(5'd8);
        step();
        add(5'd8, 5'd8, 5'd12);
        bus.flush = 1'b1;
        #1;
        chk("fl_pcw", 32'(bus.pc_write), 32'd1);
        step();
        bus.flush = 1'b0;
        chk("fl_ctrl", 32'(ex_ctrl()), 32'd0);
        chk("fl_cnt", 32'(bus.stall_count), 32'd1);
        chk("fl_rd", 32'(bus.ex_rd), 32'd12);

        // jump with garbage decoder reg_write / mem_read
        drive(6'b000010, 5'd8, 5'd8, 5'd0, 10'b0_0_x_0_0_0_1_1_00);
        #1;
        chk("j_pcw", 32'(bus.pc_write), 32'd1);
        step();
        chk("j_rw", 32'(bus.ex_reg_write), 32'd0);
        chk("j_mrd", 32'(bus.ex_mem_read), 32'd0);
        chk("j_jmp", 32'(bus.ex_jump), 32'd1);

        // saturation of the 2-bit counter from reset
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            lw(5'd7);
            step();
            add(5'd7, 5'd1, 5'd2);
            #1;
            chk("sat_pcw", 32'(bus.pc_write), 32'd0);
            step();
            chk($sformatf("sat_cnt%0d", i), 32'(bus.stall_count),
                (i < 3) ? 32'(i + 1) : 32'd3);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/id_ex_hazard_register.md
# id_ex_hazard_register

Pipeline register between the Decode (ID) and Execute (EX) stages of the 5-stage MIPS core, with load-use hazard detection built in. It captures the main control decoder's signals and ID-stage operands every cycle. When a load in EX feeds the instruction in ID, it inserts a one-cycle bubble and freezes PC and IF/ID. It also sanitises decoder don't-care outputs, so EX, MEM and WB never see a spurious memory read or register write.

## Interface
- DATA_W, 32, width of PC, operand and immediate paths
- STALL_CNT_W, 16, width of saturating stall counter
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_opcode  in  6  opcode of instruction in ID
- id_reg_dst, id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write, id_jump  in  1 each  main control decoder outputs
- id_alu_op  in  2  decoder ALUOp
- id_pc_plus4, id_rd1, id_rd2, id_imm  in  DATA_W each  PC+4, register-file reads, sign-extended immediate
- id_rs, id_rt, id_rd  in  5 each  register specifiers; id_funct in 6
- flush  in  1  branch taken / jump resolved; discard instruction in ID
- ex_reg_dst … ex_jump, ex_alu_op  out  same widths  registered control to EX
- ex_pc_plus4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_funct  out  registered datapath fields
- pc_write, if_id_write  out  1 each  0 = hold PC and IF/ID this cycle
- stall_count  out  STALL_CNT_W  saturating count of bubbles inserted

## Operation
- Sanitisation on capture (decoder emits X/incorrect values for don't-care fields):
  - mem_read stored = (id_opcode == 6'b100011).
  - reg_write stored = id_reg_write & ~id_jump.
  - reg_dst stored = (id_opcode == 6'b000000).
  - All other fields pass through unchanged.
- Source-use rules:
  - uses_rs = (id_opcode != 6'b000010).
  - uses_rt = id_opcode ∈ {000000, 101011, 000100}.
- Load-use hazard (combinational):
  - hazard = ex_mem_read & (ex_rt != 0) & ((uses_rs & ex_rt == id_rs) | (uses_rt & ex_rt == id_rt)) & ~flush.
- Per-edge priority for the next state:
  - flush: all ten control outputs load 0; datapath fields load the ID values.
  - else hazard: bubble. All ten control outputs load 0; datapath fields load the ID values; stall_count increments, saturating at all-ones.
  - else normal: load sanitised controls and ID fields.
- pc_write = if_id_write = ~hazard. Flush overrides the hazard, so no stall occurs on a discarded instruction.

## Timing
- Register latency is 1 cycle: ID values at edge N appear on ex_* after edge N.
- pc_write and if_id_write are combinational from the ex_* registers and ID inputs, valid within the same cycle.
- A load-use stall lasts exactly 1 cycle: the bubble clears ex_mem_read, so the hazard deasserts next cycle while ID still holds the same instruction.
- Back-to-back loads each give at most one stall per dependent consumer.
- Reset (async assert, sync-safe deassert at the next edge):
  - All ex_* outputs are 0.
  - stall_count is 0.
  - pc_write and if_id_write are 1, because ex_mem_read = 0.
- Reset asserted mid-stall clears the bubble state immediately; there is no residual hold after release.
- stall_count holds at 2^STALL_CNT_W−1 once reached; it does not wrap.

## Test plan
- **Reset:** drive rst_n=0 mid-cycle with non-zero inputs → all ex_* = 0, pc_write=1, stall_count=0, with no clock edge needed.
- **Load-use:** lw $t0 (op 100011, rt=8) in EX, then add with rs=8 in ID.
  - One stall cycle: pc_write=0 and ex_reg_write=0 after the edge.
  - stall_count=1; the next cycle releases with add's controls (reg_dst=1, alu_op=10).
- **No false hazard:**
  - lw rt=8 followed by addi with rt=8, rs=9 → no stall.
  - lw rt=0 followed by add rs=0 → no stall.
- **Flush priority:** hazard condition and flush=1 together → pc_write=1, all ex controls 0, stall_count unchanged.
- **Sanitisation:**
  - Jump (op 000010, decoder reg_write=1, mem_read=X) → ex_reg_write=0, ex_mem_read=0, ex_jump=1.
  - addi → ex_mem_read=0, ex_reg_dst=0.
- **Saturation:** STALL_CNT_W=2; force 5 load-use stalls → stall_count reads 1,2,3,3,3.
